ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

PS/2 keyboard receiver feeding the ping-pong game logic inside `Top`. It synchronises and deglitches the raw `PS2_clk` and `PS2_data` pins, then deframes 11-bit device-to-host frames. It decodes `E0` (extended) and `F0` (break) prefixes into per-key make/break events. It also keeps held-key flags for the four paddle keys, which the bar-movement logic consumes directly.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples required before a filtered line changes level. Legal range is 2..255.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a filtered `PS2_clk` falling edge before a partial frame is aborted. This is 2 ms at 50 MHz.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock, 50 MHz. This is the single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `PS2_clk` in 1: raw keyboard clock pin. Asynchronous, idles high.
- `PS2_data` in 1: raw keyboard data pin. Asynchronous, idles high.
- `code` out 8: last completed non-prefix scan code. Held until the next event.
- `extended` out 1: `E0` preceded `code`.
- `released` out 1: `F0` preceded `code`.
- `code_valid` out 1: one-cycle pulse; `code`, `extended` and `released` are valid on the same cycle.
- `frame_err` out 1: one-cycle pulse on a start, parity, stop or timeout failure.
- `key_state` out 4: held-key flags. [0] W (`1D`), [1] S (`1B`), [2] Up (`E0 75`), [3] Down (`E0 72`).

## Operation
Input conditioning:
- Each pin passes through a 2-FF synchroniser.
- It then feeds a filter: the output changes only after `FILTER_LEN` consecutive synchronised samples differ from the current output. Any matching sample resets the run counter.
- A falling edge is filtered clk going 1→0. It is detected by comparison with a registered previous value.
- Data is sampled from filtered data on the edge-detect cycle.

Deframing FSM (states `IDLE`, `DATA`, `PARITY`, `STOP`):
- `IDLE`: on an edge, if the sample is 0 (start bit), go to `DATA` with the bit counter at 0. If the sample is 1, ignore it and stay in `IDLE`. No error is raised.
- `DATA`: shift the sample into the shift register LSB-first. After 8 bits, go to `PARITY`.
- `PARITY`: latch the sample. Odd parity is required: the XOR of the 8 data bits and the parity bit must equal 1. Go to `STOP`.
- `STOP`: the sample must be 1 and parity must be good. Either way, return to `IDLE`.
  - On failure, pulse `frame_err` and clear both pending flags.

Byte handling for a good frame:
- `E0`: set `ext_pending`. No pulse.
- `F0`: set `brk_pending`. No pulse.
- Any other byte:
  - Drive `code` with the byte, `extended` with `ext_pending` and `released` with `brk_pending`.
  - Pulse `code_valid` and clear both pending flags.
  - If `{extended, code}` matches a tracked key, set its `key_state` bit on make and clear it on break.
  - A non-extended `75` or `72` does not affect bits 2 and 3.
  - Repeated make codes (typematic) keep the bit set and still pulse `code_valid`.

Timeout:
- A cycle counter runs while the state is not `IDLE` and resets on every edge.
- Reaching `TIMEOUT_CYCLES` forces `IDLE`, pulses `frame_err`, clears the pending flags and clears the bit counter.
- `key_state` is unchanged by a timeout.

Reset:
- State `IDLE` and all counters 0.
- Synchroniser stages and filter outputs at 1.
- `code`, `extended`, `released`, `code_valid`, `frame_err` and `key_state` all 0.
- Pending flags 0.
- Reset mid-frame discards the partial frame with no `frame_err`.

## Timing
- Pin to filtered level: 2 synchroniser cycles plus `FILTER_LEN` cycles.
- `code_valid` and `frame_err` are registered. Each asserts on the cycle after the edge-detect cycle of the stop bit and is high for exactly one cycle.
- `key_state` updates on the same cycle as `code_valid`.
- `code_valid` and `frame_err` are never asserted together.
- A timeout reaching its limit on the same cycle as an edge: the edge wins. It is processed normally and the counter resets.
- Minimum supported PS/2 clock half-period is `FILTER_LEN` + 4 cycles. Real keyboards run at 30–50 µs half-periods.

## Test plan
- Send frame `1D` with odd parity 1 → one `code_valid` pulse with `code`=`1D`, `extended`=0, `released`=0; `key_state`=4'b0001.
- Send `F0`, then `1D` → `code_valid` with `released`=1; `key_state`=4'b0000; no pulse for the `F0` byte.
- Send `E0 75`, then `E0 F0 75` → first event `extended`=1, `released`=0, `key_state`[2]=1; second event `released`=1, `key_state`[2]=0.
- Send `1B` with a wrong parity bit → `frame_err` pulse, no `code_valid`, `key_state` unchanged. Then send a good `1B` → `key_state`[1]=1.
- Send a start bit plus 4 data bits, then hold the lines high for `TIMEOUT_CYCLES` + 10 → exactly one `frame_err`. A following good frame `72` decodes with `code`=`72`.
- Inject a 2-cycle low glitch on `PS2_clk` while idle → no state change and no pulses. Assert `rst` mid-frame → all outputs 0 and no `frame_err`.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver bus: raw keyboard pins in, decoded key events out.
interface ps2_keyboard_rx_if;
    logic       PS2_clk;
    logic       PS2_data;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       frame_err;
    logic [3:0] key_state;

    // Receiver side: samples the pins, drives the event outputs.
    modport master (
        input  PS2_clk, PS2_data,
        output code, extended, released, code_valid, frame_err, key_state
    );

    // Keyboard/consumer side: drives the pins, observes events.
    modport slave (
        output PS2_clk, PS2_data,
        input  code, extended, released, code_valid, frame_err, key_state
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframing,
// E0/F0 prefix decoding and held-key flags for the four paddle keys.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic            clk,
    input logic            rst,
    ps2_keyboard_rx_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic [7:0] clk_run_q, clk_run_d, data_run_q, data_run_d;
    logic       clk_prev_q;
    logic       fall, sample;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       parity_ok_q;
    logic [TW-1:0] to_cnt_q;
    logic       ext_pending_q, brk_pending_q;
    logic [7:0] code_q;
    logic       extended_q, released_q, code_valid_q, frame_err_q;
    logic [3:0] key_state_q;

    // Level filter: flip only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_filt_d  = clk_filt_q;
        clk_run_d   = '0;
        data_filt_d = data_filt_q;
        data_run_d  = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_run_q == 8'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
            else                                 clk_run_d  = clk_run_q + 8'd1;
        end
        if (data_sync_q[1] != data_filt_q) begin
            if (data_run_q == 8'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
            else                                  data_run_d  = data_run_q + 8'd1;
        end
    end

    // Synchronisers, filter state and previous filtered clock for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_run_q   <= '0;
            data_run_q  <= '0;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.PS2_clk};
            data_sync_q <= {data_sync_q[0], bus.PS2_data};
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
            clk_run_q   <= clk_run_d;
            data_run_q  <= data_run_d;
            clk_prev_q  <= clk_filt_q;
        end
    end

    assign fall   = clk_prev_q & ~clk_filt_q;
    assign sample = data_filt_q;

    // Deframer, timeout, prefix decoding and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_ok_q   <= 1'b0;
            to_cnt_q      <= '0;
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
            code_q        <= '0;
            extended_q    <= 1'b0;
            released_q    <= 1'b0;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            key_state_q   <= '0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            // An edge always wins over a timeout landing on the same cycle.
            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!sample) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {sample, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_ok_q <= (^shift_q) ^ sample;
                        state_q     <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (sample && parity_ok_q) begin
                            if (shift_q == 8'hE0) begin
                                ext_pending_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_pending_q <= 1'b1;
                            end else begin
                                code_q        <= shift_q;
                                extended_q    <= ext_pending_q;
                                released_q    <= brk_pending_q;
                                code_valid_q  <= 1'b1;
                                ext_pending_q <= 1'b0;
                                brk_pending_q <= 1'b0;
                                case ({ext_pending_q, shift_q})
                                    9'h01D:  key_state_q[0] <= ~brk_pending_q;
                                    9'h01B:  key_state_q[1] <= ~brk_pending_q;
                                    9'h175:  key_state_q[2] <= ~brk_pending_q;
                                    9'h172:  key_state_q[3] <= ~brk_pending_q;
                                    default: ;
                                endcase
                            end
                        end else begin
                            frame_err_q   <= 1'b1;
                            ext_pending_q <= 1'b0;
                            brk_pending_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q       <= IDLE;
                    frame_err_q   <= 1'b1;
                    ext_pending_q <= 1'b0;
                    brk_pending_q <= 1'b0;
                    bit_cnt_q     <= '0;
                    to_cnt_q      <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.extended   = extended_q;
    assign bus.released   = released_q;
    assign bus.code_valid = code_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.key_state  = key_state_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed frames push expected events,
// a monitor pops and compares whenever code_valid or frame_err fires.
module tb_ps2_keyboard_rx;
    localparam int unsigned FILT    = 8;
    localparam int unsigned TIMEOUT = 1000;
    localparam int          HALF    = 20;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [3:0] ks;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_code(input logic [7:0] c, input logic e, input logic r,
                             input logic [3:0] ks);
        exp_t x;
        x.err = 1'b0; x.code = c; x.ext = e; x.rel = r; x.ks = ks;
        q.push_back(x);
    endtask

    task automatic push_err(input logic [3:0] ks);
        exp_t x;
        x.err = 1'b1; x.code = '0; x.ext = 1'b0; x.rel = 1'b0; x.ks = ks;
        q.push_back(x);
    endtask

    // One PS/2 bit: data set while clock high, then a full low/high clock cycle.
    task automatic send_bit(input logic b);
        bus.PS2_data = b;
        wait_cyc(HALF);
        bus.PS2_clk = 1'b0;
        wait_cyc(HALF);
        bus.PS2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        bus.PS2_data = 1'b1;
        wait_cyc(60);
    endtask

    // Monitor: every output event is matched against the head of the queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && (bus.code_valid || bus.frame_err)) begin
                n_cmp++;
                if (bus.code_valid && bus.frame_err) begin
                    n_bad++;
                    $display("FAIL event_both: code_valid and frame_err both high");
                end else if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL event_unexpected: got err=%0b code=%h ext=%0b rel=%0b, expected none",
                             bus.frame_err, bus.code, bus.extended, bus.released);
                end else begin
                    x = q.pop_front();
                    if (x.err) begin
                        if (!bus.frame_err || bus.key_state !== x.ks) begin
                            n_bad++;
                            $display("FAIL event_err: got err=%0b ks=%b, expected err=1 ks=%b",
                                     bus.frame_err, bus.key_state, x.ks);
                        end
                    end else if (!bus.code_valid || bus.code !== x.code ||
                                 bus.extended !== x.ext || bus.released !== x.rel ||
                                 bus.key_state !== x.ks) begin
                        n_bad++;
                        $display("FAIL event_code: got cv=%0b code=%h ext=%0b rel=%0b ks=%b, expected code=%h ext=%0b rel=%0b ks=%b",
                                 bus.code_valid, bus.code, bus.extended, bus.released,
                                 bus.key_state, x.code, x.ext, x.rel, x.ks);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        bus.PS2_clk  = 1'b1;
        bus.PS2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(5);
        check("reset_code", bus.code, 8'h00);
        check("reset_flags", {4'b0, bus.extended, bus.released, bus.code_valid, bus.frame_err},
              8'h00);
        check("reset_key_state", {4'b0, bus.key_state}, 8'h00);
        rst = 1'b0;
        wait_cyc(20);

        // W make, then W break
        push_code(8'h1D, 1'b0, 1'b0, 4'b0001);
        send_byte(8'h1D, 1'b0);
        send_byte(8'hF0, 1'b0);
        push_code(8'h1D, 1'b0, 1'b1, 4'b0000);
        send_byte(8'h1D, 1'b0);

        // Up make and break
        send_byte(8'hE0, 1'b0);
        push_code(8'h75, 1'b1, 1'b0, 4'b0100);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        push_code(8'h75, 1'b1, 1'b1, 4'b0000);
        send_byte(8'h75, 1'b0);

        // Bad parity on S, then a good S
        push_err(4'b0000);
        send_byte(8'h1B, 1'b1);
        push_code(8'h1B, 1'b0, 1'b0, 4'b0010);
        send_byte(8'h1B, 1'b0);

        // Non-extended 75 leaves the Up flag alone
        push_code(8'h75, 1'b0, 1'b0, 4'b0010);
        send_byte(8'h75, 1'b0);

        // Partial frame then idle lines: one timeout error
        push_err(4'b0010);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.PS2_data = 1'b1;
        wait_cyc(TIMEOUT + 60);
        push_code(8'h72, 1'b0, 1'b0, 4'b0010);
        send_byte(8'h72, 1'b0);

        // Down make, then a typematic repeat
        send_byte(8'hE0, 1'b0);
        push_code(8'h72, 1'b1, 1'b0, 4'b1010);
        send_byte(8'h72, 1'b0);
        send_byte(8'hE0, 1'b0);
        push_code(8'h72, 1'b1, 1'b0, 4'b1010);
        send_byte(8'h72, 1'b0);

        // Short clock glitch while idle is filtered out
        bus.PS2_clk = 1'b0;
        wait_cyc(2);
        bus.PS2_clk = 1'b1;
        wait_cyc(60);
        check("glitch_key_state", {4'b0, bus.key_state}, 8'h0A);
        check("glitch_code", bus.code, 8'h72);

        // Reset mid-frame discards everything silently
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bus.PS2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        check("midrst_code", bus.code, 8'h00);
        check("midrst_flags", {4'b0, bus.extended, bus.released, bus.code_valid, bus.frame_err},
              8'h00);
        check("midrst_key_state", {4'b0, bus.key_state}, 8'h00);
        rst = 1'b0;
        wait_cyc(TIMEOUT + 60);

        // Receiver recovers cleanly after reset
        push_code(8'h1D, 1'b0, 1'b0, 4'b0001);
        send_byte(8'h1D, 1'b0);

        guard = 0;
        while (q.size() != 0 && guard < 5000) begin
            wait_cyc(1);
            guard++;
        end
        check("queue_drained", 8'(q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
